// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types, sizing constants and the round-robin pick helper for rr_sel_arbiter.
package rr_sel_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_DATA_W   = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;
  localparam int unsigned SEL_W        = $clog2(DEF_NUM_REQ);
  localparam int unsigned MAX_REQ      = 8;
  localparam int unsigned MAX_SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // First set request scanning upward from ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_SEL_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !p.found && req[idx[MAX_SEL_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = MAX_SEL_W'(idx);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Requester-side bus of rr_sel_arbiter: requests, operands, grant and result.
interface rr_sel_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
);
  localparam int unsigned W_SEL = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [W_SEL-1:0]          sel;
  logic                      busy;
  logic                      out_valid;
  logic [DATA_W-1:0]         data_out;
  logic                      timeout;

  modport master (
    output req, data_in,
    input  gnt, sel, busy, out_valid, data_out, timeout
  );

  modport slave (
    input  req, data_in,
    output gnt, sel, busy, out_valid, data_out, timeout
  );
endinterface

// File: rtl/rr_sel_datapath.sv
// Registered operand mux plus select-index offset adder feeding data_out/out_valid.
module rr_sel_datapath #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned SW      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [SW-1:0]             i_sel,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_data
);

  logic [DATA_W-1:0] w_op;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Out-of-range select falls back to operand 0.
  always_comb begin
    w_op = i_data[DATA_W-1:0];
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (i_sel == SW'(i)) w_op = i_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_en;
      if (i_en) r_data <= w_op + DATA_W'(i_sel);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter/sequencer for the shared select/offset datapath.
// Optional hold limit with forced release enabled by RR_SEL_ARB_TIMEOUT_EN.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_sel_arbiter_if.slave    bus
);

  localparam int unsigned SW = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ) || (DATA_W < 1) || (MAX_HOLD < 1)) begin : g_bad_param
    $error("rr_sel_arbiter: unsupported parameter set");
  end

  state_e             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SW-1:0]      r_sel, w_sel_nxt;
  logic [SW-1:0]      r_rr_ptr, w_ptr_nxt;
  logic               r_busy;
  logic               w_req_sel;
  logic               w_force;
  logic               w_dp_en;
  logic [SW-1:0]      w_sel_inc;
  logic [SW-1:0]      w_pick_idx;
  pick_t              w_pick;

  assign w_pick     = rr_pick(MAX_REQ'(bus.req), MAX_SEL_W'(r_rr_ptr), NUM_REQ);
  assign w_pick_idx = SW'(w_pick.idx);
  assign w_sel_inc  = (r_sel == SW'(NUM_REQ - 1)) ? '0 : r_sel + SW'(1);

  // Request of the currently granted requester; out-of-range select reads as dropped.
  always_comb begin
    w_req_sel = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_sel == SW'(i)) w_req_sel = bus.req[i];
    end
  end

`ifdef RR_SEL_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_force = (r_state == GRANT) && w_req_sel && (r_hold == HOLD_W'(MAX_HOLD - 1));

  // Hold counter is zero on GRANT entry and counts GRANT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state != GRANT) r_hold <= '0;
      else if (!w_force)    r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_force     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sel    <= w_sel_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_rr_ptr;
    w_dp_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = NUM_REQ'(1) << w_pick_idx;
          w_sel_nxt   = w_pick_idx;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!w_req_sel || w_force) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_sel_inc;
        end else begin
          w_dp_en = 1'b1;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  rr_sel_datapath #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SW      (SW)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_dp_en),
    .i_sel   (r_sel),
    .i_data  (bus.data_in),
    .o_valid (bus.out_valid),
    .o_data  (bus.data_out)
  );

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (NUM_REQ=4, DATA_W=4, MAX_HOLD=8).
module tb_rr_sel_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  rr_sel_arbiter_if #(.NUM_REQ(4), .DATA_W(4)) bus_if ();

  rr_sel_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         order [5];
  logic [3:0] exp_g;

  initial begin
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    bus_if.req = 4'b0000;
    // operands: r3=E r2=3 r1=7 r0=2
    bus_if.data_in = 16'hE372;
    #12;
    chk("rst_gnt",  32'(bus_if.gnt), 0);
    chk("rst_sel",  32'(bus_if.sel), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_ov",   32'(bus_if.out_valid), 0);
    chk("rst_dout", 32'(bus_if.data_out), 0);
    chk("rst_to",   32'(bus_if.timeout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 32'(bus_if.gnt), 0);

    // single request on 2
    bus_if.req = 4'b0100;
    tick();
    chk("s_gnt",  32'(bus_if.gnt), 32'h4);
    chk("s_sel",  32'(bus_if.sel), 2);
    chk("s_busy", 32'(bus_if.busy), 1);
    chk("s_ov0",  32'(bus_if.out_valid), 0);
    tick();
    chk("s_ov1",  32'(bus_if.out_valid), 1);
    chk("s_dout", 32'(bus_if.data_out), 32'h5);
    bus_if.req = 4'b0000;
    tick();
    chk("s_rel_gnt",  32'(bus_if.gnt), 0);
    chk("s_rel_ov",   32'(bus_if.out_valid), 0);
    chk("s_rel_busy", 32'(bus_if.busy), 1);
    tick();
    chk("s_idle_busy", 32'(bus_if.busy), 0);

    // wrap arithmetic: E + 3 -> 1
    bus_if.req = 4'b1000;
    tick();
    chk("w_gnt", 32'(bus_if.gnt), 32'h8);
    chk("w_sel", 32'(bus_if.sel), 3);
    tick();
    chk("w_dout", 32'(bus_if.data_out), 32'h1);
    chk("w_ov",   32'(bus_if.out_valid), 1);
    bus_if.req = 4'b0000;
    tick();
    tick();

    // round robin with all requesting
    bus_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'(1 << order[i]);
      tick();
      chk($sformatf("rr_gnt%0d", i), 32'(bus_if.gnt), 32'(exp_g));
      tick();
      tick();
      bus_if.req = bus_if.req & ~exp_g;
      tick();
      chk($sformatf("rr_rel%0d", i), 32'(bus_if.gnt), 0);
      bus_if.req = (i == 4) ? 4'b0000 : 4'b1111;
      tick();
      chk($sformatf("rr_idle%0d", i), 32'(bus_if.busy), 0);
    end

    // fairness: move pointer to 2, then 3 wins over 0
    bus_if.req = 4'b0010;
    tick();
    chk("f_pre_gnt", 32'(bus_if.gnt), 32'h2);
    bus_if.req = 4'b0000;
    tick();
    tick();
    bus_if.req = 4'b1001;
    tick();
    chk("f_gnt3", 32'(bus_if.gnt), 32'h8);
    bus_if.req = 4'b1011;
    tick();
    chk("f_ignore", 32'(bus_if.gnt), 32'h8);
    chk("f_dout",   32'(bus_if.data_out), 32'h1);
    bus_if.req = 4'b0011;
    tick();
    chk("f_rel", 32'(bus_if.gnt), 0);
    tick();
    tick();
    chk("f_gnt0", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0000;
    tick();
    tick();

    // asynchronous reset in the middle of a grant
    bus_if.req = 4'b0010;
    tick();
    chk("r_gnt", 32'(bus_if.gnt), 32'h2);
    tick();
    chk("r_dout", 32'(bus_if.data_out), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("r_now_gnt",  32'(bus_if.gnt), 0);
    chk("r_now_ov",   32'(bus_if.out_valid), 0);
    chk("r_now_dout", 32'(bus_if.data_out), 0);
    chk("r_now_busy", 32'(bus_if.busy), 0);
    chk("r_now_sel",  32'(bus_if.sel), 0);
    bus_if.req = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("r_ptr0_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0000;
    tick();
    tick();

    // long hold on requester 1
    bus_if.req = 4'b0010;
    tick();
    chk("h_gnt", 32'(bus_if.gnt), 32'h2);
`ifdef RR_SEL_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("h_hold%0d", i), 32'(bus_if.gnt), 32'h2);
      chk($sformatf("h_to%0d", i), 32'(bus_if.timeout), 0);
    end
    tick();
    chk("h_force_gnt", 32'(bus_if.gnt), 0);
    chk("h_force_to",  32'(bus_if.timeout), 1);
    chk("h_force_ov",  32'(bus_if.out_valid), 0);
    tick();
    chk("h_idle_gnt", 32'(bus_if.gnt), 0);
    chk("h_idle_to",  32'(bus_if.timeout), 0);
    tick();
    chk("h_regrant", 32'(bus_if.gnt), 32'h2);
    for (int i = 0; i < 8; i++) tick();
`else
    for (int i = 0; i < 19; i++) begin
      tick();
      chk($sformatf("h_hold%0d", i), 32'(bus_if.gnt), 32'h2);
      chk($sformatf("h_to%0d", i), 32'(bus_if.timeout), 0);
    end
`endif
    bus_if.req = 4'b0000;
    tick();
    tick();
    chk("end_busy", 32'(bus_if.busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4-way select/offset datapath. NUM_REQ requesters each present a DATA_W operand. The block grants exactly one requester at a time and drives the encoded select. It produces a registered result equal to the selected operand plus its select index. It sits in front of the shared adder/mux and guarantees the select decode is never left unassigned: every state and sel decode has an explicit default arm.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand/result width
MAX_HOLD, 8, maximum grant length in cycles; used only with the optional feature

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request, level; held high for the whole transaction
data_in  input  NUM_REQ*DATA_W  packed operands; requester i at bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, registered
sel  output  $clog2(NUM_REQ)  encoded index of granted requester, registered
busy  output  1  high in any state other than IDLE
out_valid  output  1  data_out valid
data_out  output  DATA_W  registered result
timeout  output  1  one-cycle pulse on forced release; tied 0 when feature is off

Behaviour:
- One clock domain (clk). Asynchronous active-low reset rst_n takes effect immediately, including mid-grant.
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, out_valid=0, data_out=0, timeout=0, rr_ptr=0.
- FSM states: IDLE, GRANT, RELEASE. Any unencoded state value goes to IDLE with gnt cleared (default arm).
- IDLE:
  - If req != 0, choose the first set bit scanning from index rr_ptr upward, wrapping modulo NUM_REQ.
  - At the next edge: gnt=onehot(winner), sel=winner, state=GRANT.
  - If req == 0, remain in IDLE.
- GRANT:
  - Each cycle: data_out <= (data_in[sel] + sel) truncated to DATA_W (wrap, no saturation); out_valid <= 1.
  - When req[sel]==0, at the next edge: state=RELEASE, gnt=0, out_valid=0, rr_ptr=(sel+1) mod NUM_REQ.
  - Other requesters' req changes are ignored while in GRANT.
- RELEASE:
  - One dead cycle with gnt=0 and out_valid=0.
  - Always goes to IDLE. Arbitration for pending requests resumes in IDLE.
- Latency:
  - req high sampled at edge N (from IDLE) gives gnt at N+1, first out_valid at N+2.
  - req drop sampled at edge M gives gnt low at M+1, out_valid low at M+1.
- Minimum turnaround between back-to-back grants: 2 cycles with gnt low (RELEASE, IDLE).
- sel decode for operand selection uses an explicit default: an out-of-range sel yields operand 0.
- Simultaneous requests are resolved purely by rr_ptr. No requester waits more than NUM_REQ-1 grants.
- The granted requester dropping req in the same cycle another raises it: normal release path; the new requester is served later per rr_ptr.

Optional Feature:
RR_SEL_ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD while req[sel] is still high, the FSM forces RELEASE, pulses timeout for one cycle (concurrent with gnt dropping), and sets rr_ptr=(sel+1) mod NUM_REQ.
  - The requester must re-arbitrate.
- Undefined: no counter is built, timeout is constant 0, and grants last until req drops.

Decomposition:
- Package rr_sel_arbiter_pkg:
  - state enum typedef (IDLE, GRANT, RELEASE, 2-bit)
  - localparam SEL_W=$clog2(NUM_REQ)
  - function rr_pick(req, ptr) returning winner index and a found flag
- Sub-module rr_sel_datapath: registered operand mux plus adder plus out_valid, with its own default sel arm. The FSM/pointer logic stays in the top.

Test Plan:
- Reset mid-grant: req=4'b0010, assert rst_n=0 during GRANT -> gnt, out_valid, data_out, busy all 0 immediately; rr_ptr=0 after release.
- Single request: req=4'b0100, data_in[2]=4'h3 -> gnt=4'b0100 one edge later; data_out=4'h5, out_valid=1 the following edge; drop req -> gnt=0 next edge, one RELEASE cycle.
- Round robin: req=4'b1111 held, each grant released after 3 cycles -> grant order 0,1,2,3,0.
- Wrap arithmetic: sel=3, data_in[3]=4'hE -> data_out=4'h1.
- Fairness: rr_ptr=2 with req=4'b1001 -> requester 3 granted first, then 0.
- With RR_SEL_ARB_TIMEOUT_EN, MAX_HOLD=8: req[1] held high for 20 cycles -> forced release after 8 GRANT cycles, timeout=1 for exactly one cycle, re-grant to 1 only after the RELEASE and IDLE cycles.
